// File: rtl/batch_metrics_unit.sv
// batch_metrics_unit: per-sample argmax / correctness / loss over a streamed
// score vector, plus per-batch and running accuracy/loss accumulators.
// Optional feature macro: BATCH_METRICS_TOP2_EN (runner-up tracking and
// top-2 correctness outputs). With the macro undefined those ports are absent.
module batch_metrics_unit #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4,
  parameter int BATCH_SIZE  = 32,
  parameter int LOSS_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [IDX_WIDTH-1:0]  label,
  input  logic                  score_valid,
  input  logic [DATA_WIDTH-1:0] score,
  input  logic                  clear_totals,
  output logic                  score_ready,
  output logic                  sample_done,
  output logic [IDX_WIDTH-1:0]  pred_class,
  output logic                  pred_correct,
  output logic                  label_err,
  output logic                  batch_done,
  output logic [LOSS_WIDTH-1:0] batch_loss,
  output logic [CNT_WIDTH-1:0]  batch_correct,
  output logic [CNT_WIDTH-1:0]  total_samples,
  output logic [CNT_WIDTH-1:0]  total_correct
`ifdef BATCH_METRICS_TOP2_EN
 ,output logic                  pred_top2_correct,
  output logic [CNT_WIDTH-1:0]  batch_top2_correct
`endif
);

  // Batch sample index only needs to reach BATCH_SIZE-1.
  localparam int BIDX_W = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Per-sample collection registers
  logic [IDX_WIDTH-1:0]  label_reg;
  logic [IDX_WIDTH-1:0]  idx_reg;
  logic [DATA_WIDTH-1:0] max_val_reg;
  logic [IDX_WIDTH-1:0]  max_idx_reg;
  logic [DATA_WIDTH-1:0] label_score_reg;

  // Batch accumulators (internal, restart at each batch boundary)
  logic [LOSS_WIDTH-1:0] batch_loss_acc_reg;
  logic [CNT_WIDTH-1:0]  batch_correct_acc_reg;
  logic [BIDX_W-1:0]     batch_idx_reg;

  // Combinational per-sample results, valid while in RESOLVE
  logic                  last_score;
  logic                  label_err_now;
  logic                  hit_top1;
  logic [DATA_WIDTH-1:0] sample_loss;
  logic [LOSS_WIDTH:0]   loss_sum;
  logic [LOSS_WIDTH-1:0] batch_loss_next;
  logic [CNT_WIDTH-1:0]  batch_correct_next;
  logic [CNT_WIDTH-1:0]  total_samples_next;
  logic [CNT_WIDTH-1:0]  total_correct_next;
  logic                  batch_last;

`ifdef BATCH_METRICS_TOP2_EN
  logic [DATA_WIDTH-1:0] second_val_reg;
  logic [IDX_WIDTH-1:0]  second_idx_reg;
  logic                  second_valid_reg;
  logic [CNT_WIDTH-1:0]  batch_top2_acc_reg;
  logic                  hit_top2;
  logic [CNT_WIDTH-1:0]  batch_top2_next;
`endif

  // Saturating increment by a single bit; holds at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] a,
                                                   input logic               b);
    logic [CNT_WIDTH-1:0] r;
    if (b && (&a)) r = a;
    else           r = a + CNT_WIDTH'(b);
    return r;
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state and score_ready
  always_comb begin
    state_next  = state_reg;
    score_ready = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) state_next = COLLECT;
      end
      COLLECT: begin
        score_ready = 1'b1;
        if (score_valid && last_score) state_next = RESOLVE;
      end
      RESOLVE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign last_score = (idx_reg == IDX_WIDTH'(NUM_CLASSES - 1));

  // Score collection: argmax tracking (ties keep lowest index) and score[label] capture
  always_ff @(posedge clk) begin
    if (reset) begin
      label_reg       <= '0;
      idx_reg         <= '0;
      max_val_reg     <= '0;
      max_idx_reg     <= '0;
      label_score_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable) begin
            label_reg       <= label;
            idx_reg         <= '0;
            max_val_reg     <= '0;
            max_idx_reg     <= '0;
            label_score_reg <= '0;
          end
        end
        COLLECT: begin
          if (score_valid) begin
            idx_reg <= idx_reg + 1'b1;
            if ((idx_reg == '0) || (score > max_val_reg)) begin
              max_val_reg <= score;
              max_idx_reg <= idx_reg;
            end
            if (idx_reg == label_reg) label_score_reg <= score;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BATCH_METRICS_TOP2_EN
  // Runner-up tracking: demoted max, or first/strictly-greater non-max score
  always_ff @(posedge clk) begin
    if (reset) begin
      second_val_reg   <= '0;
      second_idx_reg   <= '0;
      second_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (enable) begin
            second_val_reg   <= '0;
            second_idx_reg   <= '0;
            second_valid_reg <= 1'b0;
          end
        end
        COLLECT: begin
          if (score_valid) begin
            if (idx_reg == '0) begin
              second_valid_reg <= 1'b0;
            end else if (score > max_val_reg) begin
              second_val_reg   <= max_val_reg;
              second_idx_reg   <= max_idx_reg;
              second_valid_reg <= 1'b1;
            end else if (!second_valid_reg || (score > second_val_reg)) begin
              second_val_reg   <= score;
              second_idx_reg   <= idx_reg;
              second_valid_reg <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end
`endif

  // Per-sample results and saturating next values for every accumulator
  always_comb begin
    label_err_now = ({1'b0, label_reg} >= (IDX_WIDTH + 1)'(NUM_CLASSES));
    hit_top1      = !label_err_now && (max_idx_reg == label_reg);
    // (2^W - 1) - x is simply the bitwise complement of x.
    sample_loss   = label_err_now ? {DATA_WIDTH{1'b1}} : ~label_score_reg;
    loss_sum      = {1'b0, batch_loss_acc_reg} + (LOSS_WIDTH + 1)'(sample_loss);
    batch_loss_next    = loss_sum[LOSS_WIDTH] ? {LOSS_WIDTH{1'b1}} : loss_sum[LOSS_WIDTH-1:0];
    batch_correct_next = sat_inc(batch_correct_acc_reg, hit_top1);
    total_samples_next = sat_inc(total_samples, 1'b1);
    total_correct_next = sat_inc(total_correct, hit_top1);
    batch_last         = (batch_idx_reg == BIDX_W'(BATCH_SIZE - 1));
  end

`ifdef BATCH_METRICS_TOP2_EN
  // Top-2 hit: label matches max or a valid runner-up
  always_comb begin
    hit_top2 = !label_err_now &&
               ((max_idx_reg == label_reg) ||
                (second_valid_reg && (second_idx_reg == label_reg)));
    batch_top2_next = sat_inc(batch_top2_acc_reg, hit_top2);
  end
`endif

  // Sample result outputs, registered on RESOLVE exit (even when cleared)
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_done  <= 1'b0;
      pred_class   <= '0;
      pred_correct <= 1'b0;
      label_err    <= 1'b0;
`ifdef BATCH_METRICS_TOP2_EN
      pred_top2_correct <= 1'b0;
`endif
    end else begin
      sample_done <= 1'b0;
      if (state_reg == RESOLVE) begin
        sample_done  <= 1'b1;
        pred_class   <= max_idx_reg;
        pred_correct <= hit_top1;
        label_err    <= label_err_now;
`ifdef BATCH_METRICS_TOP2_EN
        pred_top2_correct <= hit_top2;
`endif
      end
    end
  end

  // Batch and running accumulators; clear_totals takes priority over the RESOLVE update
  always_ff @(posedge clk) begin
    if (reset) begin
      batch_done            <= 1'b0;
      batch_loss            <= '0;
      batch_correct         <= '0;
      total_samples         <= '0;
      total_correct         <= '0;
      batch_loss_acc_reg    <= '0;
      batch_correct_acc_reg <= '0;
      batch_idx_reg         <= '0;
`ifdef BATCH_METRICS_TOP2_EN
      batch_top2_correct    <= '0;
      batch_top2_acc_reg    <= '0;
`endif
    end else begin
      batch_done <= 1'b0;
      if (clear_totals) begin
        total_samples         <= '0;
        total_correct         <= '0;
        batch_loss_acc_reg    <= '0;
        batch_correct_acc_reg <= '0;
        batch_idx_reg         <= '0;
`ifdef BATCH_METRICS_TOP2_EN
        batch_top2_acc_reg    <= '0;
`endif
      end else if (state_reg == RESOLVE) begin
        total_samples <= total_samples_next;
        total_correct <= total_correct_next;
        if (batch_last) begin
          batch_done            <= 1'b1;
          batch_loss            <= batch_loss_next;
          batch_correct         <= batch_correct_next;
          batch_loss_acc_reg    <= '0;
          batch_correct_acc_reg <= '0;
          batch_idx_reg         <= '0;
`ifdef BATCH_METRICS_TOP2_EN
          batch_top2_correct    <= batch_top2_next;
          batch_top2_acc_reg    <= '0;
`endif
        end else begin
          batch_loss_acc_reg    <= batch_loss_next;
          batch_correct_acc_reg <= batch_correct_next;
          batch_idx_reg         <= batch_idx_reg + 1'b1;
`ifdef BATCH_METRICS_TOP2_EN
          batch_top2_acc_reg    <= batch_top2_next;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_batch_metrics_unit.sv
// Directed testbench for batch_metrics_unit (10 classes, batch of 4).
module tb_batch_metrics_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  label;
  logic        score_valid;
  logic [15:0] score;
  logic        clear_totals;
  logic        score_ready;
  logic        sample_done;
  logic [3:0]  pred_class;
  logic        pred_correct;
  logic        label_err;
  logic        batch_done;
  logic [31:0] batch_loss;
  logic [15:0] batch_correct;
  logic [15:0] total_samples;
  logic [15:0] total_correct;
`ifdef BATCH_METRICS_TOP2_EN
  logic        pred_top2_correct;
  logic [15:0] batch_top2_correct;
`endif

  batch_metrics_unit #(
    .DATA_WIDTH(16), .NUM_CLASSES(10), .IDX_WIDTH(4),
    .BATCH_SIZE(4), .LOSS_WIDTH(32), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .label(label),
    .score_valid(score_valid), .score(score), .clear_totals(clear_totals),
    .score_ready(score_ready), .sample_done(sample_done),
    .pred_class(pred_class), .pred_correct(pred_correct), .label_err(label_err),
    .batch_done(batch_done), .batch_loss(batch_loss), .batch_correct(batch_correct),
    .total_samples(total_samples), .total_correct(total_correct)
`ifdef BATCH_METRICS_TOP2_EN
   ,.pred_top2_correct(pred_top2_correct), .batch_top2_correct(batch_top2_correct)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] scores [0:9];
  logic [3:0]  got_pred;
  logic        got_correct;
  logic        got_err;
  logic        got_bdone;
`ifdef BATCH_METRICS_TOP2_EN
  logic        got_top2;
`endif

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ramp 100*i with a dominant class 3
  task automatic fill_ramp();
    for (int i = 0; i < 10; i++) scores[i] = 16'(100 * i);
    scores[3] = 16'hF000;
  endtask

  task automatic fill_hot(input int hot, input logic [15:0] hot_val, input logic [15:0] base);
    for (int i = 0; i < 10; i++) scores[i] = base;
    scores[hot] = hot_val;
  endtask

  // Runs one sample from IDLE; starts and ends on a falling edge.
  task automatic run_sample(input logic [3:0] lbl, input bit bubble, input bit clr);
    enable = 1'b1;
    label  = lbl;
    @(negedge clk);
    enable = 1'b0;
    check_value("ready_in_collect", score_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (bubble && i == 5) begin
        score_valid = 1'b0;
        score       = 16'hFFFF;
        enable      = 1'b1;
        label       = 4'd0;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
      end
      score_valid = 1'b1;
      score       = scores[i];
      @(negedge clk);
    end
    score_valid = 1'b0;
    // RESOLVE cycle
    check_value("done_early", sample_done, 1'b0);
    clear_totals = clr;
    @(negedge clk);
    clear_totals = 1'b0;
    check_value("done_pulse", sample_done, 1'b1);
    got_pred    = pred_class;
    got_correct = pred_correct;
    got_err     = label_err;
    got_bdone   = batch_done;
`ifdef BATCH_METRICS_TOP2_EN
    got_top2    = pred_top2_correct;
`endif
    $display("sample label=%0d pred=%0d correct=%0b err=%0b batch_done=%0b total=%0d",
             lbl, got_pred, got_correct, got_err, got_bdone, total_samples);
    @(negedge clk);
    check_value("done_width", {sample_done, batch_done}, 2'b00);
  endtask

  // Sample whose label score gives the requested loss; label is argmax
  task automatic loss_sample(input logic [3:0] lbl, input logic [15:0] loss);
    fill_hot(int'(lbl), 16'hFFFF - loss, 16'h0000);
    run_sample(lbl, 1'b0, 1'b0);
  endtask

  initial begin
    bit seen_done;
    reset = 1'b1; enable = 1'b0; label = '0; score_valid = 1'b0;
    score = '0; clear_totals = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_value("rst_ready", score_ready, 1'b0);
    check_value("rst_flags", {sample_done, pred_correct, label_err, batch_done}, 4'b0);
    check_value("rst_pred", pred_class, 4'd0);
    check_value("rst_batch", {batch_loss, batch_correct}, 48'd0);
    check_value("rst_totals", {total_samples, total_correct}, 32'd0);
    // score_valid in IDLE is ignored
    score_valid = 1'b1; score = 16'h1234;
    @(negedge clk);
    score_valid = 1'b0;
    check_value("idle_valid_ready", score_ready, 1'b0);
    @(negedge clk);
    check_value("idle_valid_done", sample_done, 1'b0);

    // Batch A: dominant class, two tie cases, bubbled stream
    fill_ramp();
    run_sample(4'd3, 1'b0, 1'b0);
    check_value("s1_pred", {got_pred, got_correct, got_err}, {4'd3, 1'b1, 1'b0});
    fill_hot(0, 16'h0500, 16'h0500);
    run_sample(4'd0, 1'b0, 1'b0);
    check_value("tie_l0", {got_pred, got_correct}, {4'd0, 1'b1});
    run_sample(4'd5, 1'b0, 1'b0);
    check_value("tie_l5", {got_pred, got_correct}, {4'd0, 1'b0});
    check_value("a_no_bdone", got_bdone, 1'b0);
    fill_ramp();
    run_sample(4'd3, 1'b1, 1'b0);
    check_value("bubble_pred", {got_pred, got_correct, got_err}, {4'd3, 1'b1, 1'b0});
    check_value("a_bdone", got_bdone, 1'b1);
    // 0x0FFF*2 + 0xFAFF*2
    check_value("a_loss", batch_loss, 32'h0002_15FC);
    check_value("a_correct", batch_correct, 16'd3);
    check_value("a_totals", {total_samples, total_correct}, {16'd4, 16'd3});

    // Batch B: losses 0x10..0x40, last one incorrect
    loss_sample(4'd1, 16'h0010);
    loss_sample(4'd2, 16'h0020);
    loss_sample(4'd4, 16'h0030);
    check_value("b_hold_loss", batch_loss, 32'h0002_15FC);
    check_value("b_hold_bdone", got_bdone, 1'b0);
    fill_hot(6, 16'hFFBF, 16'h0000);
    scores[0] = 16'hFFFF;
    run_sample(4'd6, 1'b0, 1'b0);
    check_value("b4_pred", {got_pred, got_correct}, {4'd0, 1'b0});
    check_value("b_bdone", got_bdone, 1'b1);
    check_value("b_loss", batch_loss, 32'h0000_00A0);
    check_value("b_correct", batch_correct, 16'd3);

    // 5th sample with out-of-range label: batch outputs held
    fill_ramp();
    run_sample(4'd12, 1'b0, 1'b0);
    check_value("err_flags", {got_pred, got_correct, got_err}, {4'd3, 1'b0, 1'b1});
    check_value("err_no_bdone", got_bdone, 1'b0);
    check_value("err_hold", {batch_loss, batch_correct}, {32'h0000_00A0, 16'd3});
    loss_sample(4'd1, 16'h0010);
    loss_sample(4'd1, 16'h0010);
    loss_sample(4'd1, 16'h0010);
    check_value("c_bdone", got_bdone, 1'b1);
    check_value("c_loss", batch_loss, 32'h0001_002F);
    check_value("c_correct", batch_correct, 16'd3);
    check_value("c_totals", {total_samples, total_correct}, {16'd12, 16'd9});

    // Reset after 5 accepted scores aborts the sample
    fill_ramp();
    enable = 1'b1; label = 4'd3;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      score_valid = 1'b1; score = scores[i];
      @(negedge clk);
    end
    score_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_value("abort_ready", score_ready, 1'b0);
    check_value("abort_totals", {total_samples, total_correct}, 32'd0);
    check_value("abort_batch", {batch_loss, batch_correct}, 48'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (sample_done) seen_done = 1'b1;
      @(negedge clk);
    end
    check_value("abort_no_done", seen_done, 1'b0);
    run_sample(4'd3, 1'b0, 1'b0);
    check_value("after_abort", {got_pred, total_samples}, {4'd3, 16'd1});

    // clear_totals on the RESOLVE exit edge
    run_sample(4'd3, 1'b0, 1'b1);
    check_value("clr_pred", {got_pred, got_correct}, {4'd3, 1'b1});
    check_value("clr_totals", {total_samples, total_correct}, 32'd0);
    check_value("clr_no_bdone", got_bdone, 1'b0);
    // Batch index restarted: batch_done on the 4th sample only
    for (int k = 0; k < 4; k++) begin
      loss_sample(4'd2, 16'h0010);
      check_value("clr_batch_pos", got_bdone, (k == 3) ? 1'b1 : 1'b0);
    end
    check_value("clr_batch_res", {batch_loss, batch_correct}, {32'h0000_0040, 16'd4});
    check_value("clr_batch_tot", total_samples, 16'd4);

`ifdef BATCH_METRICS_TOP2_EN
    check_value("top2_batch", batch_top2_correct, 16'd4);
    fill_hot(2, 16'h9000, 16'h0100);
    scores[5] = 16'h8000;
    run_sample(4'd5, 1'b0, 1'b0);
    check_value("top2_runner", {got_pred, got_correct, got_top2}, {4'd2, 1'b0, 1'b1});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
